ws2812_bit_encoder: RTL and testbench
=====================================

# ws2812_bit_encoder

Consumes 24-bit pixel words from the SPI slave's receive side (`mosi_rx` strobe + `mosi_data_out`) on the system-bus clock. It buffers them in a small FIFO and serialises each word MSB-first onto the WS2812 one-wire data line with cycle-exact high/low timing. When the buffer drains, it holds the line low for the latch/reset interval and flags frame completion. It is the stage directly downstream of `spi_slave` and drives the LED strip pin.

## Interface
- `T0H_CYC`, 20: high time of a '0' bit in `clk_sb` cycles (400 ns at 50 MHz)
- `T1H_CYC`, 40: high time of a '1' bit (800 ns)
- `BIT_CYC`, 62: total bit period (1.24 µs); must exceed `T1H_CYC`
- `RESET_CYC`, 2500: low hold for latch (50 µs)
- `FIFO_DEPTH`, 16: pixel words buffered; power of two, ≥2
- `clk_sb` in 1: system-bus clock; only clock
- `rst` in 1: reset, asynchronous, active-high
- `pix_wr` in 1: single-cycle write strobe (driven from `mosi_rx`)
- `pix_data` in 24: pixel word, sampled when `pix_wr`=1
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words
- `overflow` out 1: sticky; a write was dropped while full
- `busy` out 1: state ≠ IDLE
- `frame_done` out 1: one-cycle pulse at end of latch interval
- `dout` out 1: WS2812 data line

## Operation
- Reset values: `dout`=0, `busy`=0, `frame_done`=0, `overflow`=0, `fifo_full`=0, FIFO empty, state IDLE, counters 0.
- FIFO write: accepted when `pix_wr`=1 and (not full, or a pop occurs in the same cycle). Otherwise the word is dropped and `overflow` is set; it clears only on `rst`.
- FSM states:
  - IDLE: `dout`=0. FIFO non-empty → LOAD.
  - LOAD: pop head into 24-bit shift register, bit index=23 → HIGH.
  - HIGH: `dout`=1 for `T1H_CYC` (bit=1) or `T0H_CYC` (bit=0) cycles → LOW.
  - LOW: `dout`=0 until the bit period reaches `BIT_CYC` total.
    - More bits remaining → HIGH with the next bit.
    - Index 0 done and FIFO non-empty → pop in the final LOW cycle and go directly to HIGH.
    - Index 0 done and FIFO empty → LATCH.
  - LATCH: `dout`=0 for `RESET_CYC` cycles, then pulse `frame_done` and go to IDLE. Writes during LATCH are buffered. LATCH is never aborted.
- Bit order: bit 23 first, bit 0 last. Bit counter and phase counter are sized `$clog2` of their maxima and wrap to 0 at each new bit.
- `rst` mid-word forces `dout`=0 immediately. The FIFO contents and the partial word are discarded.

## Timing
- First word: `pix_wr` in cycle 0 → LOAD in cycle 1 → `dout` rises in cycle 2.
- Every bit period is exactly `BIT_CYC` cycles, including across word boundaries (no gap between back-to-back words).
- After the last bit's LOW phase completes, `dout` stays low `RESET_CYC` cycles. `frame_done` is asserted in the last of them, and `busy` falls the next cycle.
- `fifo_full` and `overflow` are registered and update the cycle after the causing write.

## Configuration
- `WS2812_RGB_SWAP_EN` defined: `pix_data` is interpreted as {R,G,B}. It is reordered to {G,R,B} at FIFO write, so the strip receives its native GRB order.
- Not defined: words are transmitted exactly as received.

## Structure
- `ws2812_pkg`: FSM state enum (IDLE, LOAD, HIGH, LOW, LATCH), default timing constants, 24-bit pixel word typedef.
- One sub-module, `ws2812_fifo`: synchronous FIFO with push/pop/full/empty, depth-parameterised, async active-high reset.
- The encoder top holds the FSM, phase counter, bit counter and shift register.

## Test plan
- Single word 24'h800001 after reset: `dout` high 40 cycles, low 22, then 22×(20 high, 42 low), then 40 high, 22 low; then 2500 low and one `frame_done` pulse.
- Three back-to-back words: bit periods measure 62 cycles continuously across both word boundaries, and exactly one `frame_done` occurs.
- Write 17 words with no drain (transmitter occupied): `fifo_full`=1 after the 16th buffered word; the 17th is dropped, `overflow`=1, and 16 words are transmitted afterwards.
- Write during LATCH: the latch runs its full 2500 cycles, then `frame_done` pulses, then the new word starts in the normal IDLE→LOAD→HIGH sequence.
- Assert `rst` at bit 10 of a word: `dout`=0 the same cycle, all outputs return to reset values, and no further toggling occurs without a new write.
- With `WS2812_RGB_SWAP_EN`, write 24'hFF0000: transmitted as 8 zero bits, 8 one bits, then 8 zero bits (24'h00FF00).

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 bit encoder.
// Holds the encoder state enum, the pixel word type, the default cycle
// counts at a 50 MHz bus clock, and the RGB-to-GRB reorder helper used when
// WS2812_RGB_SWAP_EN is defined.
package ws2812_pkg;

    localparam int unsigned PIX_W          = 24;
    localparam int unsigned T0H_CYC_DEF    = 20;    // 400 ns
    localparam int unsigned T1H_CYC_DEF    = 40;    // 800 ns
    localparam int unsigned BIT_CYC_DEF    = 62;    // 1.24 us
    localparam int unsigned RESET_CYC_DEF  = 2500;  // 50 us latch
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        LATCH = 3'd4
    } ws2812_state_e;

    // {R,G,B} in, {G,R,B} out: the strip expects green first.
    function automatic pixel_t rgb_to_grb(input pixel_t rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_fifo.sv
// Synchronous FIFO buffering pixel words between the SPI receive strobe and
// the bit serialiser. Depth must be a power of two so the pointers wrap
// naturally. Full/empty are registered flags derived from the next occupancy.
module ws2812_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // A push while full is only legal when a pop frees the slot this cycle.
    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    // Next occupancy from the push/pop combination.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/ws2812_bit_encoder.sv
// WS2812 one-wire bit encoder.
// Buffers 24-bit pixel words and serialises them MSB-first with cycle-exact
// high/low timing, then holds the line low for the latch interval and pulses
// frame_done. Optional feature macro: WS2812_RGB_SWAP_EN reorders incoming
// {R,G,B} words to {G,R,B} at FIFO write; undefined, words pass unchanged.
//
// Input handshake: pix_wr is a single-cycle strobe with no ready/back-pressure.
// A strobe is accepted when the FIFO is not full or a pop happens in the same
// cycle; otherwise the word is dropped and overflow sticks high until rst.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H_CYC    = T0H_CYC_DEF,
    parameter int unsigned T1H_CYC    = T1H_CYC_DEF,
    parameter int unsigned BIT_CYC    = BIT_CYC_DEF,
    parameter int unsigned RESET_CYC  = RESET_CYC_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk_sb,
    input  logic              rst,
    input  logic              pix_wr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy,
    output logic              frame_done,
    output logic              dout,
    output ws2812_state_e     dbg_state
);

    localparam int PH_W = $clog2(BIT_CYC);
    localparam int BI_W = $clog2(PIX_W);
    localparam int LA_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BIT_CYC - 1);
    localparam logic [PH_W-1:0] T1H_LAST = PH_W'(T1H_CYC - 1);
    localparam logic [PH_W-1:0] T0H_LAST = PH_W'(T0H_CYC - 1);
    localparam logic [BI_W-1:0] BI_TOP   = BI_W'(PIX_W - 1);
    localparam logic [LA_W-1:0] LA_LAST  = LA_W'(RESET_CYC - 1);

    ws2812_state_e   r_state;
    ws2812_state_e   w_state_nxt;
    logic [PH_W-1:0] r_phase;
    logic [PH_W-1:0] w_phase_nxt;
    logic [BI_W-1:0] r_bit_idx;
    logic [BI_W-1:0] w_bit_idx_nxt;
    pixel_t          r_shift;
    pixel_t          w_shift_nxt;
    logic [LA_W-1:0] r_latch_cnt;
    logic [LA_W-1:0] w_latch_nxt;
    logic            r_dout;
    logic            r_overflow;

    pixel_t          w_wr_data;
    pixel_t          w_fifo_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_push;
    logic            w_pop;

`ifdef WS2812_RGB_SWAP_EN
    assign w_wr_data = rgb_to_grb(pix_data);
`else
    assign w_wr_data = pix_data;
`endif

    assign w_push = pix_wr && (!w_fifo_full || w_pop);

    ws2812_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .i_clk   (clk_sb),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_wr_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state, counters and pop decision for the serialiser.
    // The phase counter restarts at 0 on every bit so HIGH+LOW always sums
    // to BIT_CYC, including the direct LOW->HIGH hop between words.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_latch_nxt   = r_latch_cnt;
        w_pop         = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A strobe in IDLE is always accepted, so LOAD will find data.
                if (!w_fifo_empty || pix_wr) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_pop         = 1'b1;
                w_shift_nxt   = w_fifo_head;
                w_bit_idx_nxt = BI_TOP;
                w_phase_nxt   = '0;
                w_state_nxt   = HIGH;
            end
            HIGH: begin
                w_phase_nxt = r_phase + PH_W'(1);
                if (r_phase == (r_shift[PIX_W-1] ? T1H_LAST : T0H_LAST)) begin
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (r_phase == PH_LAST) begin
                    w_phase_nxt = '0;
                    if (r_bit_idx != '0) begin
                        w_bit_idx_nxt = r_bit_idx - BI_W'(1);
                        w_shift_nxt   = {r_shift[PIX_W-2:0], 1'b0};
                        w_state_nxt   = HIGH;
                    end else if (!w_fifo_empty) begin
                        // Pop in the last LOW cycle so the next word has no gap.
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_fifo_head;
                        w_bit_idx_nxt = BI_TOP;
                        w_state_nxt   = HIGH;
                    end else begin
                        w_latch_nxt = '0;
                        w_state_nxt = LATCH;
                    end
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            LATCH: begin
                if (r_latch_cnt == LA_LAST) begin
                    w_latch_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_latch_nxt = r_latch_cnt + LA_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and the registered data line; rst drops dout at once.
    always_ff @(posedge clk_sb or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_latch_cnt <= '0;
            r_dout      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_latch_cnt <= w_latch_nxt;
            r_dout      <= (w_state_nxt == HIGH);
        end
    end

    // Sticky record of a strobe that found the FIFO full with no pop.
    always_ff @(posedge clk_sb or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (pix_wr && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign dout       = r_dout;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == LATCH) && (r_latch_cnt == LA_LAST);
    assign fifo_full  = w_fifo_full;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Bench for ws2812_bit_encoder: a line decoder measures every bit on dout,
// rebuilds words and checks them against a queue of expected words.
module tb_ws2812_bit_encoder;

    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int BITP  = 62;
    localparam int LATCH_LEN = 2500;
    localparam int WORD_CYC  = 24 * BITP;

    // ---------------- clock / reset ----------------
    logic        clk_sb = 1'b0;
    logic        rst;
    logic        pix_wr;
    logic [23:0] pix_data;
    logic        fifo_full;
    logic        overflow;
    logic        busy;
    logic        frame_done;
    logic        dout;
    ws2812_pkg::ws2812_state_e dbg_state;

    always #5 clk_sb = ~clk_sb;

    ws2812_bit_encoder #(
        .T0H_CYC    (T0H),
        .T1H_CYC    (T1H),
        .BIT_CYC    (BITP),
        .RESET_CYC  (LATCH_LEN),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_sb     (clk_sb),
        .rst        (rst),
        .pix_wr     (pix_wr),
        .pix_data   (pix_data),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .busy       (busy),
        .frame_done (frame_done),
        .dout       (dout),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_word(input logic [23:0] d);
`ifdef WS2812_RGB_SWAP_EN
        return {d[15:8], d[23:16], d[7:0]};
`else
        return d;
`endif
    endfunction

    // ---------------- line decoder / monitor ----------------
    int          m_hi_cnt   = 0;
    int          m_lo_cnt   = 0;
    int          m_last_hi  = 0;
    int          m_bits     = 0;
    int          m_words    = 0;
    int          m_frames   = 0;
    bit          m_in_frame = 0;
    bit          m_prev     = 0;
    bit          m_fd_prev  = 0;
    logic [23:0] m_word     = '0;

    always begin
        @(posedge clk_sb);
        #2;
        if (rst) begin
            m_hi_cnt   = 0;
            m_lo_cnt   = 0;
            m_bits     = 0;
            m_in_frame = 0;
            m_prev     = 0;
            m_fd_prev  = 0;
        end else begin
            if (dout) begin
                if (!m_prev) begin
                    if (m_in_frame) check("bit_period", 32'(m_last_hi + m_lo_cnt), 32'(BITP));
                    m_hi_cnt = 1;
                end else begin
                    m_hi_cnt++;
                end
            end else begin
                if (m_prev) begin
                    check("high_len_legal", 32'((m_hi_cnt == T1H) || (m_hi_cnt == T0H)), 32'd1);
                    m_word     = {m_word[22:0], (m_hi_cnt == T1H)};
                    m_bits++;
                    m_last_hi  = m_hi_cnt;
                    m_lo_cnt   = 1;
                    m_in_frame = 1;
                    if (m_bits == 24) begin
                        logic [23:0] e;
                        if (exp_q.size() == 0) begin
                            check("unexpected_word", 32'(m_word), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("word", 32'(m_word), 32'(e));
                        end
                        m_bits = 0;
                        m_words++;
                    end
                end else begin
                    m_lo_cnt++;
                end
            end
            if (m_fd_prev) begin
                check("frame_done_one_cycle", 32'(frame_done), 32'd0);
                check("busy_falls_after_done", 32'(busy), 32'd0);
            end
            if (frame_done) begin
                check("latch_low_len", 32'(m_lo_cnt), 32'((BITP - m_last_hi) + LATCH_LEN));
                check("frame_whole_words", 32'(m_bits), 32'd0);
                m_frames++;
                m_in_frame = 0;
            end
            m_fd_prev = frame_done;
            m_prev    = dout;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; holds the strobe for exactly one rising edge.
    task automatic write_word(input logic [23:0] d, input bit accept);
        pix_wr   = 1'b1;
        pix_data = d;
        if (accept) exp_q.push_back(model_word(d));
        @(negedge clk_sb);
        pix_wr   = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (m_frames < target && n < budget) begin
            @(negedge clk_sb);
            n++;
        end
        check("frame_count", 32'(m_frames), 32'(target));
    endtask

    task automatic wait_words(input int target, input int budget);
        int n;
        n = 0;
        while (m_words < target && n < budget) begin
            @(negedge clk_sb);
            n++;
        end
        check("word_count", 32'(m_words), 32'(target));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int f0;
        int w0;
        int n;
        int n_hi;

        rst      = 1'b1;
        pix_wr   = 1'b0;
        pix_data = '0;
        repeat (3) @(negedge clk_sb);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ws2812_pkg::IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk_sb);

        // Single word: first-word latency and full bit/latch timing.
        f0 = m_frames;
        write_word(24'h800001, 1'b1);
        check("load_cycle_dout", 32'(dout), 32'd0);
        check("load_cycle_busy", 32'(busy), 32'd1);
        @(negedge clk_sb);
        check("first_rise", 32'(dout), 32'd1);
        wait_frames(f0 + 1, WORD_CYC + LATCH_LEN + 100);
        repeat (5) @(negedge clk_sb);

        // Three back-to-back words: continuous 62-cycle periods, one frame.
        f0 = m_frames;
        for (int i = 0; i < 3; i++) write_word(24'($urandom()), 1'b1);
        wait_frames(f0 + 1, 3 * WORD_CYC + LATCH_LEN + 100);
        repeat (100) @(negedge clk_sb);
        check("single_frame_for_three", 32'(m_frames), 32'(f0 + 1));

        // Overflow: occupy the transmitter, then push 17 words.
        f0 = m_frames;
        w0 = m_words;
        write_word(24'($urandom()), 1'b1);
        repeat (5) @(negedge clk_sb);
        for (int i = 0; i < 16; i++) begin
            write_word(24'($urandom_range(0, 24'hFFFFFF)), 1'b1);
            if (i == 14) check("not_full_at_15", 32'(fifo_full), 32'd0);
            if (i == 15) begin
                check("full_at_16", 32'(fifo_full), 32'd1);
                check("no_overflow_at_16", 32'(overflow), 32'd0);
            end
        end
        write_word(24'hABCDEF, 1'b0);
        check("overflow_set", 32'(overflow), 32'd1);
        check("still_full", 32'(fifo_full), 32'd1);
        wait_frames(f0 + 1, 17 * WORD_CYC + LATCH_LEN + 200);
        check("overflow_words_sent", 32'(m_words - w0), 32'd17);
        check("overflow_sticky", 32'(overflow), 32'd1);
        repeat (5) @(negedge clk_sb);

        // Write during LATCH: latch completes, then normal restart.
        f0 = m_frames;
        w0 = m_words;
        write_word(24'h5A5A5A, 1'b1);
        wait_words(w0 + 1, WORD_CYC + 100);
        repeat (300) @(negedge clk_sb);
        check("in_latch", 32'(dbg_state), 32'(ws2812_pkg::LATCH));
        write_word(24'hC3_3C_0F, 1'b1);
        wait_frames(f0 + 1, LATCH_LEN + 100);
        n = 0;
        while (!dout && n < 10) begin
            @(negedge clk_sb);
            n++;
        end
        check("restart_latency", 32'(n), 32'd3);
        wait_frames(f0 + 2, WORD_CYC + LATCH_LEN + 100);
        repeat (5) @(negedge clk_sb);

        // Reset in the middle of a word.
        f0 = m_frames;
        write_word(24'hF0F0F0, 1'b0);
        n = 0;
        while (!(m_bits == 10 && dout) && n < WORD_CYC) begin
            @(negedge clk_sb);
            n++;
        end
        check("reached_bit_10", 32'(m_bits), 32'd10);
        rst = 1'b1;
        #1;
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_fifo_full", 32'(fifo_full), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ws2812_pkg::IDLE));
        @(negedge clk_sb);
        rst = 1'b0;
        n_hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sb);
            if (dout) n_hi++;
        end
        check("quiet_after_rst", 32'(n_hi), 32'd0);
        check("no_frame_after_rst", 32'(m_frames), 32'(f0));

        // Channel order word.
        f0 = m_frames;
        write_word(24'hFF0000, 1'b1);
        wait_frames(f0 + 1, WORD_CYC + LATCH_LEN + 100);
        repeat (5) @(negedge clk_sb);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
